mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and data access.
// Data wins by default; a starvation limit forces fetch through after a run of contested data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_flush_fetch,
  output logic [31:0] o_if_rdata,
  output logic        o_if_done,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [3:0]  i_dm_be,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_done,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_bus_err
);

  localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned TcntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);
  localparam logic [TcntW-1:0]   TcntLast  = TcntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;
  typedef enum logic {OwnIf, OwnDm} owner_e;

  state_e              r_state, w_state_d;
  owner_e              r_owner, w_owner_d;
  logic                r_kill, w_kill_d;
  logic [StreakW-1:0]  r_streak, w_streak_d;
  logic [TcntW-1:0]    r_tcnt, w_tcnt_d;
  logic                r_mem_req, w_mem_req_d;
  logic                r_mem_we, w_mem_we_d;
  logic [3:0]          r_mem_be, w_mem_be_d;
  logic [31:0]         r_mem_addr, w_mem_addr_d;
  logic [31:0]         r_mem_wdata, w_mem_wdata_d;
  logic [31:0]         r_if_rdata, w_if_rdata_d;
  logic [31:0]         r_dm_rdata, w_dm_rdata_d;
  logic                r_if_done, w_if_done_d;
  logic                r_dm_done, w_dm_done_d;
  logic                r_bus_err, w_bus_err_d;

  logic w_grant_dm;
  logic w_grant_if;
  logic w_timeout;
  logic w_finish;
  logic w_if_visible;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_owner     <= OwnIf;
      r_kill      <= 1'b0;
      r_streak    <= '0;
      r_tcnt      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_if_rdata  <= 32'h0;
      r_dm_rdata  <= 32'h0;
      r_if_done   <= 1'b0;
      r_dm_done   <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_owner     <= w_owner_d;
      r_kill      <= w_kill_d;
      r_streak    <= w_streak_d;
      r_tcnt      <= w_tcnt_d;
      r_mem_req   <= w_mem_req_d;
      r_mem_we    <= w_mem_we_d;
      r_mem_be    <= w_mem_be_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_if_rdata  <= w_if_rdata_d;
      r_dm_rdata  <= w_dm_rdata_d;
      r_if_done   <= w_if_done_d;
      r_dm_done   <= w_dm_done_d;
      r_bus_err   <= w_bus_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_owner_d     = r_owner;
    w_kill_d      = r_kill;
    w_streak_d    = r_streak;
    w_tcnt_d      = r_tcnt;
    w_mem_req_d   = r_mem_req;
    w_mem_we_d    = r_mem_we;
    w_mem_be_d    = r_mem_be;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_if_rdata_d  = r_if_rdata;
    w_dm_rdata_d  = r_dm_rdata;
    w_if_done_d   = 1'b0;
    w_dm_done_d   = 1'b0;
    w_bus_err_d   = 1'b0;
    w_grant_dm    = 1'b0;
    w_grant_if    = 1'b0;
    w_timeout     = 1'b0;
    w_finish      = 1'b0;
    w_if_visible  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_grant_dm = i_dm_req && !(i_if_req && (r_streak == StreakMax));
        w_grant_if = !w_grant_dm && i_if_req && !i_flush_fetch;
        if (w_grant_dm) begin
          w_owner_d     = OwnDm;
          w_mem_we_d    = i_dm_we;
          w_mem_be_d    = i_dm_be;
          w_mem_addr_d  = i_dm_addr;
          w_mem_wdata_d = i_dm_wdata;
          // Only contested data grants count toward forcing fetch through.
          if (i_if_req) begin
            w_streak_d = (r_streak == StreakMax) ? r_streak : r_streak + 1'b1;
          end else begin
            w_streak_d = '0;
          end
        end else if (w_grant_if) begin
          w_owner_d     = OwnIf;
          w_mem_we_d    = 1'b0;
          w_mem_be_d    = 4'hF;
          w_mem_addr_d  = i_if_addr;
          w_mem_wdata_d = 32'h0;
          w_streak_d    = '0;
        end
        if (w_grant_dm || w_grant_if) begin
          w_mem_req_d = 1'b1;
          w_tcnt_d    = '0;
          w_kill_d    = 1'b0;
          w_state_d   = StBusy;
        end
      end

      StBusy: begin
        if ((r_owner == OwnIf) && i_flush_fetch) begin
          w_kill_d = 1'b1;
        end
        w_timeout = !i_mem_ack && (r_tcnt == TcntLast);
        w_finish  = i_mem_ack || w_timeout;
        if (w_finish) begin
          w_mem_req_d = 1'b0;
          w_state_d   = StResp;
          if (r_owner == OwnDm) begin
            w_dm_done_d = 1'b1;
            w_bus_err_d = w_timeout;
            if (w_timeout) begin
              w_dm_rdata_d = 32'h0;
            end else if (!r_mem_we) begin
              w_dm_rdata_d = i_mem_rdata;
            end
          end else begin
            w_if_rdata_d = w_timeout ? 32'h0 : i_mem_rdata;
            // done is registered, so a flush on the completing edge is the last one that can kill it
            w_if_visible = !(r_kill || i_flush_fetch);
            w_if_done_d  = w_if_visible;
            w_bus_err_d  = w_timeout && w_if_visible;
          end
        end else begin
          w_tcnt_d = r_tcnt + 1'b1;
        end
      end

      StResp: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign o_if_rdata  = r_if_rdata;
  assign o_if_done   = r_if_done;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_dm_done   = r_dm_done;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_be    = r_mem_be;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences for contention,
// flush, timeout and reset; completions are checked against a scoreboard queue.
module tb_mem_arbiter;

  localparam int Never = 255;
  localparam int Tmo   = 8;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  mem_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT      (Tmo)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_if_req      (if_req),
    .i_if_addr     (if_addr),
    .i_flush_fetch (flush),
    .o_if_rdata    (if_rdata),
    .o_if_done     (if_done),
    .i_dm_req      (dm_req),
    .i_dm_we       (dm_we),
    .i_dm_be       (dm_be),
    .i_dm_addr     (dm_addr),
    .i_dm_wdata    (dm_wdata),
    .o_dm_rdata    (dm_rdata),
    .o_dm_done     (dm_done),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .o_mem_be      (mem_be),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata),
    .i_mem_ack     (mem_ack),
    .o_bus_err     (bus_err)
  );

  typedef struct {
    bit          is_dm;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wt;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_bad = 0;

  // memory model controls, written by the main sequence only
  int          mem_wait = 0;
  logic [31:0] mem_data = 32'h0;
  int          kick = 0;

  wire [136:0] outs = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_rdata, dm_rdata,
                       if_done, dm_done, bus_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit is_dm, input logic [31:0] rd, input bit err);
    exp_t e;
    e.is_dm = is_dm;
    e.rdata = rd;
    e.err   = err;
    sb_q.push_back(e);
  endtask

  // Memory model: acks after mem_wait BUSY cycles, never when mem_wait==Never,
  // and raises one stray ack whenever kick changes.
  initial begin
    int cnt;
    int kick_seen;
    cnt       = 0;
    kick_seen = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      #2;
      if (mem_ack) begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        cnt       = 0;
      end else if (kick != kick_seen) begin
        kick_seen = kick;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
      end else if (!mem_req) begin
        cnt = 0;
      end else if (mem_wait != Never) begin
        if (cnt == mem_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_data;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (if_done || dm_done) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected_done: got if_done=%0b dm_done=%0b, expected none",
                   if_done, dm_done);
        end else begin
          e = sb_q.pop_front();
          check("sb_owner", dm_done, e.is_dm);
          check("sb_rdata", dm_done ? dm_rdata : if_rdata, e.rdata);
          check("sb_err", bus_err, e.err);
          check("sb_single_done", if_done & dm_done, 0);
        end
      end else begin
        check("err_without_done", bus_err, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_req(input vec_t v, input string tag);
    int          lat;
    int          reqc;
    bit          got;
    bit          bad_hold;
    logic [68:0] exp_bus;
    logic [68:0] act_bus;
    @(negedge clk);
    mem_wait = v.wt;
    mem_data = v.mdata;
    if (v.is_dm) begin
      dm_req   = 1'b1;
      dm_we    = v.we;
      dm_be    = v.be;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
      exp_bus  = {v.we, v.be, v.addr, v.wdata};
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
      exp_bus = {1'b0, 4'hF, v.addr, 32'h0};
    end
    push_exp(v.is_dm, v.exp_rdata, v.exp_err);
    got = 0; lat = 0; reqc = 0; bad_hold = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (mem_req) begin
        reqc++;
        act_bus = {mem_we, mem_be, mem_addr, v.is_dm ? mem_wdata : 32'h0};
        if (act_bus !== exp_bus) bad_hold = 1;
      end
      if (v.is_dm ? dm_done : if_done) begin
        got    = 1;
        lat    = c + 1;
        dm_req = 1'b0;
        if_req = 1'b0;
      end
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_latency"}, lat, (v.wt == Never) ? Tmo + 1 : v.wt + 2);
    check({tag, "_req_cycles"}, reqc, (v.wt == Never) ? Tmo : v.wt + 1);
    check({tag, "_bus_fields"}, bad_hold, 0);
  endtask

  initial begin
    bit exp_dm[10];
    int streak;
    int ng;
    int nd;
    bit prev;
    bit got;
    int reqc;
    int early;
    bit g300;
    bit d300;

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; flush = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;

    //        dm we be     addr          wdata          wt     mdata          exp_rdata      err
    vecs[0] = '{0, 0, 4'hF, 32'h0000_0100, 32'h0,         0,     32'h0050_0093, 32'h0050_0093, 0};
    vecs[1] = '{1, 1, 4'h3, 32'h0000_2004, 32'hDEAD_BEEF, 2,     32'h1234_5678, 32'h0,         0};
    vecs[2] = '{1, 0, 4'hF, 32'h0000_2008, 32'h0000_1111, 1,     32'hCAFE_F00D, 32'hCAFE_F00D, 0};
    vecs[3] = '{1, 1, 4'hF, 32'h0000_200C, 32'h0A0B_0C0D, 0,     32'h1111_1111, 32'hCAFE_F00D, 0};
    vecs[4] = '{0, 0, 4'hF, 32'h0000_0104, 32'h0,         3,     32'h00A0_0113, 32'h00A0_0113, 0};
    vecs[5] = '{1, 0, 4'hF, 32'h0000_2010, 32'h0,         Never, 32'h0,         32'h0,         1};
    vecs[6] = '{0, 0, 4'hF, 32'h0000_0108, 32'h0,         Never, 32'h0,         32'h0,         1};
    vecs[7] = '{1, 1, 4'hC, 32'h0000_2014, 32'h0BEE_F000, 1,     32'h7777_7777, 32'h0,         0};
    vecs[8] = '{1, 1, 4'h1, 32'h0000_2200, 32'h0000_00AA, 0,     32'h9999_9999, 32'h0,         0};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs, 0);
    check("reset_mem_req", mem_req, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Contention: both held; order follows the starvation rule.
    streak = 0;
    for (int i = 0; i < 10; i++) begin
      exp_dm[i] = (streak != 4);
      streak    = exp_dm[i] ? streak + 1 : 0;
      push_exp(exp_dm[i], 32'h5A5A_0000, 0);
    end
    @(negedge clk);
    mem_wait = 0; mem_data = 32'h5A5A_0000;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_3000; dm_wdata = 32'h0;
    ng = 0; nd = 0; prev = 0;
    for (int c = 0; c < 60 && nd < 10; c++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        if (ng < 10) check($sformatf("grant%0d_is_dm", ng), mem_addr == 32'h0000_3000, exp_dm[ng]);
        ng++;
      end
      prev = mem_req;
      if (if_done || dm_done) nd++;
      if (nd == 10) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    check("contention_grants", ng, 10);

    // Flush with fetch request in IDLE: no fetch grant, data still allowed.
    @(negedge clk);
    mem_wait = 0; mem_data = 32'h2400_2400;
    if_req = 1'b1; if_addr = 32'h0000_0400; flush = 1'b1;
    @(negedge clk);
    check("fi_no_if_grant", mem_req, 0);
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_2400; dm_wdata = 32'h0;
    push_exp(1, 32'h2400_2400, 0);
    @(negedge clk);
    check("fi_dm_granted", {mem_req, mem_addr}, {1'b1, 32'h0000_2400});
    if_req = 1'b0; flush = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (dm_done) begin
        got = 1;
        dm_req = 1'b0;
      end
    end
    dm_req = 1'b0;
    check("fi_dm_done", got, 1);

    // Flush in the 2nd BUSY cycle of a fetch: bus completes, no if_done, refetch follows.
    @(negedge clk);
    mem_wait = 2; mem_data = 32'h3000_0ACE;
    if_req = 1'b1; if_addr = 32'h0000_0200;
    reqc = 0; early = 0; g300 = 0; d300 = 0;
    for (int c = 0; c < 40 && !d300; c++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h0000_0200) reqc++;
      if (!g300 && if_done) early++;
      if (!g300 && mem_req && mem_addr == 32'h0000_0300) begin
        g300 = 1;
        push_exp(0, 32'h3000_0ACE, 0);
      end else if (g300 && if_done) begin
        d300   = 1;
        if_req = 1'b0;
      end
      if (c == 1) begin
        flush  = 1'b1;
        if_req = 1'b0;
      end
      if (c == 2) begin
        flush   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0300;
      end
    end
    if_req = 1'b0; flush = 1'b0;
    check("fl_bus_cycles", reqc, 3);
    check("fl_killed_done", early, 0);
    check("fl_refetch_grant", g300, 1);
    check("fl_refetch_done", d300, 1);

    // Reset while BUSY, then a stray ack one cycle after release.
    @(negedge clk);
    mem_wait = Never;
    dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF; dm_addr = 32'h0000_2100; dm_wdata = 32'h55;
    @(negedge clk);
    check("rb_busy", mem_req, 1);
    @(negedge clk);
    rst = 1'b1; dm_req = 1'b0;
    @(negedge clk);
    check("rb_outputs_zero", outs, 0);
    rst = 1'b0;
    @(negedge clk);
    kick = kick + 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rb_idle%0d", c), {mem_req, if_done, dm_done, bus_err}, 0);
    end

    do_req(vecs[8], "post_reset");

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
